div_unit: RTL
=============

# div_unit

Multi-cycle iterative divider for DIV/DIVU, the producer of the `DIV_data` operand that the HI write-data select routes into HI. It accepts a start pulse from the control unit, runs a 32-iteration restoring division on operand magnitudes, and applies sign correction. It then presents the remainder (HI source) and quotient (LO source) with a one-cycle `done` pulse. The controller holds in its DIV state until `done`, then asserts the HI/LO write selects.

## Interface
- `WIDTH`, default 32: operand and result width; the only supported value is 32.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a division; sampled only when `busy`=0.
- `sign`  input  1  1 selects DIV (signed), 0 selects DIVU (unsigned); latched with `start`.
- `dividend`  input  32  rs operand; latched with `start`.
- `divisor`  input  32  rt operand; latched with `start`.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  one-cycle pulse; results valid in this cycle and held afterwards.
- `quotient`  output  32  LO write source.
- `remainder`  output  32  HI write source (`DIV_data`).
- `div_zero`  output  1  present only with `DIV_ZERO_FLAG_EN`; see Configuration.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE with `start`=1:
  - latch `sign`, raw dividend and raw divisor;
  - latch magnitudes: two's-complement absolute value when `sign`=1, raw value otherwise;
  - clear the partial remainder; set the iteration counter to 0; go to CALC.
- CALC, one restoring step per cycle:
  - shift {rem, quo} left by 1, bringing the dividend MSB into rem;
  - trial = rem − |divisor| in 33 bits; if non-negative, rem=trial and quo LSB=1, else quo LSB=0;
  - the counter is 5 bits; after iteration 31 go to SIGN.
- SIGN:
  - if `sign`=1: negate the quotient when the dividend and divisor signs differ; the remainder takes the dividend's sign;
  - register the results, pulse `done`, return to IDLE.
- Divisor = 0 overrides sign correction: quotient = 32'hFFFFFFFF, remainder = raw latched dividend, for both DIV and DIVU.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This is the natural wrap; no special case.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `quotient`/`remainder` change only in the SIGN cycle and hold until the next SIGN.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, counter 0.
- Start sampled at edge E0: `busy`=1 from after E0 through E33. E1..E32 are CALC; E33 is SIGN.
- After E33: `done`=1 for exactly one cycle, `busy`=0, results valid. Latency is 33 cycles from the start edge to `done`.
- `start` in the `done` cycle is accepted (state is IDLE); the new division's `done` comes 33 cycles later.
- `rst` in any cycle, including CALC or SIGN, aborts the division. All outputs return to their reset values at that edge, and no `done` is issued for the aborted operation.

## Configuration
- `DIV_ZERO_FLAG_EN` defined:
  - a zero divisor at start goes IDLE→SIGN, skipping CALC, so `done` is 1 cycle after the start edge;
  - `div_zero`=1 together with `done`, registered and held until the next start is accepted;
  - results are the same override values as above.
- Not defined: the `div_zero` port is absent; a zero divisor runs the full 33-cycle sequence with the same override results.

## Structure
- Shared package `div_pkg`: state enum (IDLE, CALC, SIGN), `DIV_ITER` = 32, counter width 5.
- Sub-module `div_step`: purely combinational single restoring iteration, mapping {rem, quo, divisor} to {rem', quo'}. It is instantiated once; the main module holds the registers and FSM.

## Test plan
- DIVU 100 / 7 → `done` exactly 33 cycles after start; quotient 14, remainder 2; `busy` high for 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); DIV 7 / 0xFFFFFFFE (−2) → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU same operands → quotient 0, remainder 0x80000000.
- DIVU 0x12345678 / 0 → quotient 0xFFFFFFFF, remainder 0x12345678.
  - With `DIV_ZERO_FLAG_EN`: `done` and `div_zero` one cycle after start.
  - Without it: `done` after 33 cycles.
- Start 100/7, pulse `start` with 50/5 at cycle 10 → ignored; result 14/2.
- Start a division, assert `rst` at cycle 20 → all outputs 0 and no `done`. A new DIVU 9/3 then completes 33 cycles later with quotient 3, remainder 0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
package div_pkg;

    // Controller states: accept operands, iterate, apply sign correction
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_e;

    // One restoring iteration per result bit
    localparam int unsigned DIV_ITER = 32;

    // Iteration counter width, enough to count DIV_ITER steps
    localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts {rem, quo} left by one, trial-subtracts the divisor magnitude in
// WIDTH+1 bits and keeps the difference only when it is non-negative.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction; the borrow bit decides restore versus keep
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        if (trial[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
        end else begin
            rem_o = trial[WIDTH-1:0];
        end
        quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: 32-iteration restoring divider for DIV/DIVU.
// Produces the remainder (HI source) and quotient (LO source) with a
// one-cycle done pulse 33 cycles after start.
// Optional build macro DIV_ZERO_FLAG_EN: adds the div_zero output and lets a
// zero divisor skip the iteration phase (done one cycle after start).
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    div_state_e       state_q;
    logic             sign_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_zero_q;
`endif

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvs_zero;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_mag_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Operand magnitudes at start and sign-corrected / zero-override results
    always_comb begin
        dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
        dvs_zero = (dvs_q == '0);
        quotient_d  = quo_q;
        remainder_d = rem_q;
        if (dvs_zero) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
        end else if (sign_q) begin
            if (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) begin
                quotient_d = -quo_q;
            end
            if (dvd_q[WIDTH-1]) begin
                remainder_d = -rem_q;
            end
        end
    end

    // Controller FSM with all datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_mag_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q    <= sign;
                        dvd_q     <= dividend;
                        dvs_q     <= divisor;
                        quo_q     <= dvd_mag;
                        dvs_mag_q <= dvs_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
                        state_q    <= (divisor == '0) ? SIGN : CALC;
`else
                        state_q    <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    quotient_q  <= quotient_d;
                    remainder_q <= remainder_d;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_q  <= dvs_zero;
`endif
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero  = div_zero_q;
`endif

endmodule
